// File: rtl/spi_lcd_rx.sv
// spi_lcd_rx: display-side SPI responder for loopback self-test of the picture path.
// It decodes the 4-wire display stream (CS, DC, MOSI, SCLK mode 0) and tracks the
// CASET/RASET windows. Under RAMWR it emits one addressed 24-bit pixel for every
// 3 data bytes.
// Ports:
//   i_clk, i_rst_n       system clock (>= 4x SCLK), async active-low reset
//   i_sclk, i_cs, i_dc,  raw SPI inputs (CS active low, DC 0=command 1=data)
//   i_mosi
//   o_px_valid           one-cycle pixel write pulse with o_px_x/o_px_y/o_px_rgb
//   o_cmd_valid, o_cmd   one-cycle pulse per command byte, last command byte
//   o_frame_done         pulses with the pixel written at (XE,YE)
module spi_lcd_rx #(
  parameter int unsigned COL_MAX = 239,
  parameter int unsigned ROW_MAX = 319,
  parameter int unsigned AW      = 12
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_sclk,
  input  logic          i_cs,
  input  logic          i_dc,
  input  logic          i_mosi,
  output logic          o_px_valid,
  output logic [AW-1:0] o_px_x,
  output logic [AW-1:0] o_px_y,
  output logic [23:0]   o_px_rgb,
  output logic          o_cmd_valid,
  output logic [7:0]    o_cmd,
  output logic          o_frame_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CASET = 3'd1;
  localparam logic [2:0] S_RASET = 3'd2;
  localparam logic [2:0] S_RAMWR = 3'd3;
  localparam logic [2:0] S_OTHER = 3'd4;

  // Two-stage synchronizers plus one aligned stage carrying the registered SCLK rise
  logic [1:0] sclk_sync, cs_sync, dc_sync, mosi_sync;
  logic       sclk_d, rise_q, cs_q, dc_q, mosi_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      dc_sync   <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      rise_q    <= 1'b0;
      cs_q      <= 1'b1;
      dc_q      <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], i_sclk};
      cs_sync   <= {cs_sync[0], i_cs};
      dc_sync   <= {dc_sync[0], i_dc};
      mosi_sync <= {mosi_sync[0], i_mosi};
      sclk_d    <= sclk_sync[1];
      rise_q    <= sclk_sync[1] & ~sclk_d;
      cs_q      <= cs_sync[1];
      dc_q      <= dc_sync[1];
      mosi_q    <= mosi_sync[1];
    end
  end

  // Byte assembly; deselect drops partial bits, but decode context survives
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       byte_vld, byte_dc;
  logic [7:0] byte_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt  <= 3'd0;
      shreg    <= 7'd0;
      byte_vld <= 1'b0;
      byte_dc  <= 1'b0;
      byte_q   <= 8'd0;
    end else begin
      byte_vld <= 1'b0;
      if (cs_q) begin
        bit_cnt <= 3'd0;
      end else if (rise_q) begin
        shreg   <= {shreg[5:0], mosi_q};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_vld <= 1'b1;
          byte_q   <= {shreg, mosi_q};
          byte_dc  <= dc_q;
        end
      end
    end
  end

  // Decode state
  logic [2:0]    state, state_n;
  logic [AW-1:0] xs, xe, ys, ye, x, y;
  logic [AW-1:0] xs_n, xe_n, ys_n, ye_n, x_n, y_n;
  logic [1:0]    idx, idx_n, phase, phase_n;
  logic [7:0]    r_q, g_q, r_n, g_n;
  logic          px_valid_n, cmd_valid_n, frame_done_n;
  logic [AW-1:0] px_x_n, px_y_n;
  logic [23:0]   px_rgb_n;
  logic [7:0]    cmd_n;
  logic [15:0]   xs16, xe16, ys16, ye16;

  assign xs16 = 16'(xs);
  assign xe16 = 16'(xe);
  assign ys16 = 16'(ys);
  assign ye16 = 16'(ye);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      xs           <= '0;
      xe           <= AW'(COL_MAX);
      ys           <= '0;
      ye           <= AW'(ROW_MAX);
      x            <= '0;
      y            <= '0;
      idx          <= 2'd0;
      phase        <= 2'd0;
      r_q          <= 8'd0;
      g_q          <= 8'd0;
      o_px_valid   <= 1'b0;
      o_px_x       <= '0;
      o_px_y       <= '0;
      o_px_rgb     <= 24'd0;
      o_cmd_valid  <= 1'b0;
      o_cmd        <= 8'd0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_n;
      xs           <= xs_n;
      xe           <= xe_n;
      ys           <= ys_n;
      ye           <= ye_n;
      x            <= x_n;
      y            <= y_n;
      idx          <= idx_n;
      phase        <= phase_n;
      r_q          <= r_n;
      g_q          <= g_n;
      o_px_valid   <= px_valid_n;
      o_px_x       <= px_x_n;
      o_px_y       <= px_y_n;
      o_px_rgb     <= px_rgb_n;
      o_cmd_valid  <= cmd_valid_n;
      o_cmd        <= cmd_n;
      o_frame_done <= frame_done_n;
    end
  end

  // Next-state: one step per completed byte
  always_comb begin
    state_n      = state;
    xs_n         = xs;
    xe_n         = xe;
    ys_n         = ys;
    ye_n         = ye;
    x_n          = x;
    y_n          = y;
    idx_n        = idx;
    phase_n      = phase;
    r_n          = r_q;
    g_n          = g_q;
    px_valid_n   = 1'b0;
    px_x_n       = o_px_x;
    px_y_n       = o_px_y;
    px_rgb_n     = o_px_rgb;
    cmd_valid_n  = 1'b0;
    cmd_n        = o_cmd;
    frame_done_n = 1'b0;
    if (byte_vld) begin
      if (!byte_dc) begin
        cmd_n       = byte_q;
        cmd_valid_n = 1'b1;
        idx_n       = 2'd0;
        phase_n     = 2'd0;
        case (byte_q)
          8'h2A:   state_n = S_CASET;
          8'h2B:   state_n = S_RASET;
          8'h2C: begin
            state_n = S_RAMWR;
            x_n     = xs;
            y_n     = ys;
          end
          default: state_n = S_OTHER;
        endcase
      end else begin
        case (state)
          S_CASET, S_RASET: begin
            // Window coordinates are 16-bit big-endian on the wire, kept to AW bits
            if (state == S_CASET) begin
              case (idx)
                2'd0:    xs_n = AW'({byte_q, xs16[7:0]});
                2'd1:    xs_n = AW'({xs16[15:8], byte_q});
                2'd2:    xe_n = AW'({byte_q, xe16[7:0]});
                default: xe_n = AW'({xe16[15:8], byte_q});
              endcase
            end else begin
              case (idx)
                2'd0:    ys_n = AW'({byte_q, ys16[7:0]});
                2'd1:    ys_n = AW'({ys16[15:8], byte_q});
                2'd2:    ye_n = AW'({byte_q, ye16[7:0]});
                default: ye_n = AW'({ye16[15:8], byte_q});
              endcase
            end
            idx_n = idx + 2'd1;
            if (idx == 2'd3) state_n = S_IDLE;
          end
          S_RAMWR: begin
            case (phase)
              2'd0: begin
                r_n     = byte_q;
                phase_n = 2'd1;
              end
              2'd1: begin
                g_n     = byte_q;
                phase_n = 2'd2;
              end
              default: begin
                px_valid_n = 1'b1;
                px_x_n     = x;
                px_y_n     = y;
                px_rgb_n   = {r_q, g_q, byte_q};
                phase_n    = 2'd0;
                // >= keeps an inverted window to one pixel per row / frame
                if (x >= xe) begin
                  x_n = xs;
                  if (y >= ye) begin
                    y_n          = ys;
                    frame_done_n = 1'b1;
                  end else begin
                    y_n = y + AW'(1);
                  end
                end else begin
                  x_n = x + AW'(1);
                end
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_lcd_rx.sv
// tb_spi_lcd_rx: directed SPI byte streams against a byte-level model of the
// display responder. Every cycle, the observed pulses and payloads are compared
// with model events timed 4 clocks after the sampling of the last bit's SCLK rise.
// Literal checks pin the model on the documented scenarios.
module tb_spi_lcd_rx;
  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0, cs = 1'b1, dc = 1'b0, mosi = 1'b0;
  logic          px_valid, cmd_valid, frame_done;
  logic [AW-1:0] px_x, px_y;
  logic [23:0]   px_rgb;
  logic [7:0]    cmd;

  spi_lcd_rx #(.COL_MAX(239), .ROW_MAX(319), .AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_cs(cs), .i_dc(dc), .i_mosi(mosi),
    .o_px_valid(px_valid), .o_px_x(px_x), .o_px_y(px_y), .o_px_rgb(px_rgb),
    .o_cmd_valid(cmd_valid), .o_cmd(cmd), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         due;
    bit         cv;
    logic [7:0] cmd;
    bit         pv;
    int         x, y;
    logic [23:0] rgb;
    bit         fd;
  } ev_t;
  typedef struct { int x, y; bit fd; } px_t;

  ev_t exq[$];
  px_t plog[$];

  // Model: last command, number of data bytes since it, window and write cursor
  int         m_ctx, m_n, m_xs, m_xe, m_ys, m_ye, m_x, m_y;
  logic [7:0] m_r, m_g;

  function automatic void model_reset();
    m_ctx = -1; m_n = 0;
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319; m_x = 0; m_y = 0;
    m_r = 8'd0; m_g = 8'd0;
    exq.delete();
  endfunction

  // n even writes the high byte of a 16-bit value, n odd the low byte; AW bits kept
  function automatic int put16(int old, int n, logic [7:0] b);
    if (n % 2 == 0) return ((int'(b) << 8) | (old & 255)) & 4095;
    return ((old & 'hFF00) | int'(b)) & 4095;
  endfunction

  function automatic void model_byte(bit d, logic [7:0] b, int due);
    ev_t e;
    e = '{default: 0};
    e.due = due;
    if (!d) begin
      m_ctx = int'(b); m_n = 0;
      if (b == 8'h2C) begin m_x = m_xs; m_y = m_ys; end
      e.cv = 1'b1; e.cmd = b;
      exq.push_back(e);
      return;
    end
    if (m_ctx == 'h2A && m_n < 4) begin
      if (m_n < 2) m_xs = put16(m_xs, m_n, b); else m_xe = put16(m_xe, m_n, b);
    end else if (m_ctx == 'h2B && m_n < 4) begin
      if (m_n < 2) m_ys = put16(m_ys, m_n, b); else m_ye = put16(m_ye, m_n, b);
    end else if (m_ctx == 'h2C) begin
      if (m_n % 3 == 0) m_r = b;
      else if (m_n % 3 == 1) m_g = b;
      else begin
        e.pv = 1'b1; e.x = m_x; e.y = m_y; e.rgb = {m_r, m_g, b};
        if (m_x >= m_xe) begin
          m_x = m_xs;
          if (m_y >= m_ye) begin m_y = m_ys; e.fd = 1'b1; end
          else m_y = (m_y + 1) & 4095;
        end else m_x = (m_x + 1) & 4095;
        exq.push_back(e);
      end
    end
    m_n++;
  endfunction

  // Per-cycle comparison against the model event stream
  always @(negedge clk) begin
    ev_t e;
    e = '{default: 0};
    if (exq.size() > 0 && exq[0].due < cyc) begin
      checks++; failures++;
      $display("FAIL missed_event due=%0d now=%0d", exq[0].due, cyc);
      void'(exq.pop_front());
    end
    if (exq.size() > 0 && exq[0].due == cyc) e = exq.pop_front();
    checks++;
    if ({cmd_valid, px_valid, frame_done} !== {e.cv, e.pv, e.fd}) begin
      failures++;
      $display("FAIL pulses cyc=%0d got cv/pv/fd=%b%b%b want %b%b%b",
               cyc, cmd_valid, px_valid, frame_done, e.cv, e.pv, e.fd);
    end
    if (e.cv) begin
      checks++;
      if (cmd !== e.cmd) begin
        failures++;
        $display("FAIL cmd got %h want %h", cmd, e.cmd);
      end
    end
    if (e.pv) begin
      checks++;
      if (px_x !== AW'(e.x) || px_y !== AW'(e.y) || px_rgb !== e.rgb) begin
        failures++;
        $display("FAIL pixel got (%0d,%0d,%h) want (%0d,%0d,%h)",
                 px_x, px_y, px_rgb, e.x, e.y, e.rgb);
      end
    end
    if (px_valid === 1'b1) plog.push_back('{int'(px_x), int'(px_y), frame_done});
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send the top nbits of b MSB first; a full byte is handed to the model
  task automatic send_bits(bit d, logic [7:0] b, int nbits, bit gap);
    int rise;
    rise = 0;
    for (int i = 7; i > 7 - nbits; i--) begin
      cs = 1'b0; dc = d; mosi = b[i];
      tick(4);
      sclk = 1'b1; rise = cyc;
      tick(4);
      sclk = 1'b0;
    end
    if (nbits == 8) model_byte(d, b, rise + 5);
    if (gap) begin cs = 1'b1; tick(24); end
  endtask

  task automatic sb(bit d, logic [7:0] b, bit gap = 1'b0);
    send_bits(d, b, 8, gap);
  endtask

  task automatic test1(bit gap);
    sb(0, 8'h2A, gap); sb(1, 8'h00, gap); sb(1, 8'h34, gap); sb(1, 8'h00, gap); sb(1, 8'h34, gap);
    sb(0, 8'h2B, gap); sb(1, 8'h00, gap); sb(1, 8'h5C, gap); sb(1, 8'h00, gap); sb(1, 8'h5C, gap);
    sb(0, 8'h2C, gap); sb(1, 8'hFF, gap); sb(1, 8'h00, gap); sb(1, 8'h80, gap);
    tick(8);
    chk("t1_cmd", 64'(cmd), 64'h2C);
    chk("t1_px_x", 64'(px_x), 64'd52);
    chk("t1_px_y", 64'(px_y), 64'd92);
    chk("t1_rgb", 64'(px_rgb), 64'hFF0080);
    chk("t1_npx", 64'(plog.size()), 64'd1);
    if (plog.size() == 1) chk("t1_fd", 64'(plog[0].fd), 64'd1);
  endtask

  initial begin
    int ex[7];
    int ey[7];
    ex = '{52, 53, 54, 52, 53, 54, 52};
    ey = '{92, 92, 92, 93, 93, 93, 92};
    model_reset();
    tick(5);
    chk("rst_outs", {40'(px_x), 12'(px_y), 8'(cmd), 1'(px_valid), 1'(cmd_valid), 1'(frame_done), 1'b0}, 64'd0);
    chk("rst_rgb", 64'(px_rgb), 64'd0);
    rst_n = 1'b1;
    tick(4);

    plog.delete(); test1(1'b0);

    // Window 52..54 x 92..93, seven pixels
    plog.delete();
    sb(0, 8'h2A); sb(1, 8'h00); sb(1, 8'h34); sb(1, 8'h00); sb(1, 8'h36);
    sb(0, 8'h2B); sb(1, 8'h00); sb(1, 8'h5C); sb(1, 8'h00); sb(1, 8'h5D);
    sb(0, 8'h2C);
    for (int i = 0; i < 7; i++) begin
      sb(1, 8'(i)); sb(1, 8'(16 * i)); sb(1, 8'(255 - i));
    end
    tick(8);
    chk("t2_npx", 64'(plog.size()), 64'd7);
    for (int i = 0; i < 7 && i < plog.size(); i++) begin
      chk($sformatf("t2_x%0d", i), 64'(plog[i].x), 64'(ex[i]));
      chk($sformatf("t2_y%0d", i), 64'(plog[i].y), 64'(ey[i]));
      chk($sformatf("t2_fd%0d", i), 64'(plog[i].fd), (i == 5) ? 64'd1 : 64'd0);
    end

    // Same as the first scenario with CS released between every byte
    plog.delete(); test1(1'b1);

    // Partial byte then deselect inside RAMWR
    plog.delete();
    sb(0, 8'h2C);
    send_bits(1, 8'hA5, 5, 1'b1);
    sb(1, 8'h11); sb(1, 8'h22); sb(1, 8'h33);
    tick(8);
    chk("t4_npx", 64'(plog.size()), 64'd1);
    chk("t4_rgb", 64'(px_rgb), 64'h112233);

    // Unknown command swallows its data bytes
    plog.delete();
    sb(0, 8'h01); sb(1, 8'hAA); sb(1, 8'hBB); sb(1, 8'hCC);
    tick(8);
    chk("t5_cmd", 64'(cmd), 64'h01);
    chk("t5_npx", 64'(plog.size()), 64'd0);

    // Reset mid-pixel and mid-byte
    plog.delete();
    sb(0, 8'h2C); sb(1, 8'h12); sb(1, 8'h34);
    send_bits(1, 8'h56, 3, 1'b0);
    rst_n = 1'b0; cs = 1'b1;
    model_reset();
    tick(3);
    chk("t6_rst_cmd", 64'(cmd), 64'd0);
    chk("t6_rst_rgb", 64'(px_rgb), 64'd0);
    rst_n = 1'b1;
    tick(3);
    sb(1, 8'h56);
    tick(8);
    chk("t6_npx", 64'(plog.size()), 64'd0);
    // Only XS/YS rewritten: pixels land on the default XE/YE corner
    sb(0, 8'h2A); sb(1, 8'h00); sb(1, 8'hEF);
    sb(0, 8'h2B); sb(1, 8'h01); sb(1, 8'h3F);
    sb(0, 8'h2C);
    for (int i = 0; i < 2; i++) begin
      sb(1, 8'h0A); sb(1, 8'h0B); sb(1, 8'(i));
    end
    tick(8);
    chk("t6_npx2", 64'(plog.size()), 64'd2);
    for (int i = 0; i < 2 && i < plog.size(); i++) begin
      chk($sformatf("t6_x%0d", i), 64'(plog[i].x), 64'd239);
      chk($sformatf("t6_y%0d", i), 64'(plog[i].y), 64'd319);
      chk($sformatf("t6_fd%0d", i), 64'(plog[i].fd), 64'd1);
    end

    tick(10);
    chk("queue_empty", 64'(exq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
